// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller transfer engine among NUM_REQ requesters.
// Optional NACK retry is compiled in when the macro I2C_ARB_RETRY_EN is defined.
module i2c_bus_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_W      = 24,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic [NUM_REQ-1:0]        iREQ,
    input  logic [NUM_REQ*DATA_W-1:0] iREQ_DATA,
    output logic [NUM_REQ-1:0]        oGNT,
    output logic [NUM_REQ-1:0]        oDONE,
    output logic                      oERR,
    output logic                      oBUSY,
    output logic [DATA_W-1:0]         oI2C_DATA,
    output logic                      oI2C_GO,
    input  logic                      iI2C_END,
    input  logic                      iI2C_ACK
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = ($clog2(TIMEOUT_CYC) > 20) ? $clog2(TIMEOUT_CYC) : 20;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_RETRY < 0 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("i2c_bus_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_GO,
        S_RELEASE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                go_q, go_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                tout_q, tout_d;
    logic                ack_q, ack_d;
    logic                fail_q, fail_d;
    logic [1:0]          end_sync_q, end_sync_d;
    logic [1:0]          ack_sync_q, ack_sync_d;
    logic                end_s, ack_s;

`ifdef I2C_ARB_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0]       retry_q, retry_d;
`endif

    logic [DATA_W-1:0]   req_word [NUM_REQ];
    logic                pick_found;
    logic [IW-1:0]       pick_idx;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_word[k] = iREQ_DATA[k*DATA_W +: DATA_W];
    end

    assign end_s = end_sync_q[1];
    assign ack_s = ack_sync_q[1];

    // First active request at or after the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && iREQ[IW'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        data_d     = data_q;
        tcnt_d     = '0;
        tout_d     = tout_q;
        ack_d      = ack_q;
        fail_d     = fail_q;
        end_sync_d = {end_sync_q[0], iI2C_END};
        ack_sync_d = {ack_sync_q[0], iI2C_ACK};
`ifdef I2C_ARB_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|iREQ) state_d = S_ARB;
            end
            S_ARB: begin
                if (pick_found) begin
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    data_d  = req_word[pick_idx];
                    ptr_d   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    tout_d  = 1'b0;
                    ack_d   = 1'b0;
                    fail_d  = 1'b0;
`ifdef I2C_ARB_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = S_GO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GO: begin
                // The timeout window opens when oI2C_GO is actually seen high.
                if (go_q) tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
                if (end_s) begin
                    ack_d   = ack_s;
                    state_d = S_RELEASE;
                end else if (go_q && tcnt_q == TO_LAST) begin
                    tout_d  = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (tout_q || !end_s) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (tout_q) begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end else if (!ack_q) begin
                    fail_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
`ifdef I2C_ARB_RETRY_EN
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_GO;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_DONE;
                    end
`else
                    fail_d  = 1'b1;
                    state_d = S_DONE;
`endif
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        go_d = (state_q == S_GO) && (state_d == S_GO);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            data_q     <= '0;
            go_q       <= 1'b0;
            tcnt_q     <= '0;
            tout_q     <= 1'b0;
            ack_q      <= 1'b0;
            fail_q     <= 1'b0;
            end_sync_q <= '0;
            ack_sync_q <= '0;
`ifdef I2C_ARB_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            data_q     <= data_d;
            go_q       <= go_d;
            tcnt_q     <= tcnt_d;
            tout_q     <= tout_d;
            ack_q      <= ack_d;
            fail_q     <= fail_d;
            end_sync_q <= end_sync_d;
            ack_sync_q <= ack_sync_d;
`ifdef I2C_ARB_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign oGNT      = gnt_q;
    assign oDONE     = (state_q == S_DONE) ? gnt_q : '0;
    assign oERR      = (state_q == S_DONE) && fail_q;
    assign oBUSY     = (state_q != S_IDLE);
    assign oI2C_DATA = data_q;
    assign oI2C_GO   = go_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: directed requests, a behavioural I2C controller model,
// and a monitor that checks every oDONE against the queued expectation.
module tb_i2c_bus_arbiter;

    localparam int NR = 3;
    localparam int DW = 24;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic            err;
    logic            busy;
    logic [DW-1:0]   i2c_data;
    logic            go;
    logic            end_i;
    logic            ack_i;

    int n_checks = 0;
    int n_fail   = 0;
    int nack_left = 0;
    bit hang = 1'b0;
    int go_pulses = 0;
    int go_hi = 0;
    bit go_prev = 1'b0;
    bit onehot_bad = 1'b0;

    typedef struct {
        int          idx;
        logic        err;
        logic [23:0] data;
    } exp_t;
    exp_t sb[$];

    i2c_bus_arbiter #(
        .NUM_REQ(NR),
        .DATA_W(DW),
        .MAX_RETRY(3),
        .TIMEOUT_CYC(64)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .iREQ(req),
        .iREQ_DATA(req_data),
        .oGNT(gnt),
        .oDONE(done),
        .oERR(err),
        .oBUSY(busy),
        .oI2C_DATA(i2c_data),
        .oI2C_GO(go),
        .iI2C_END(end_i),
        .iI2C_ACK(ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input int k, input logic [23:0] w, input logic e);
        exp_t x;
        x.idx = k; x.err = e; x.data = w;
        req_data[k*DW +: DW] = w;
        sb.push_back(x);
        req[k] = 1'b1;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb.size() == 0 && !busy) && n < 2000);
        if (n >= 2000) check("wait_quiet_expired", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Controller model: acknowledges a few cycles after GO, holds END until GO drops.
    initial begin
        end_i = 1'b0;
        ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (go && !hang && !rst) begin
                repeat (3) @(negedge clk);
                ack_i = (nack_left > 0);
                if (nack_left > 0) nack_left--;
                @(negedge clk);
                end_i = 1'b1;
                for (int n = 0; n < 200 && go; n++) @(negedge clk);
                @(negedge clk);
                end_i = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (go && !go_prev) go_pulses++;
            if (go) go_hi++;
            go_prev = go;
            if ($countones(gnt) > 1) onehot_bad = 1'b1;
        end
    end

    // Monitor: every oDONE pops the oldest expectation; the requester then releases iREQ.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_vec", 32'(done), 32'd1 << e.idx);
                    check("done_err", 32'(err), 32'(e.err));
                    check("done_data", 32'(i2c_data), 32'(e.data));
                end
                req = req & ~done;
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_go", 32'(go), 32'd0);
        check("rst_data", 32'(i2c_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single request, latency to GO and normal completion.
        go_pulses = 0;
        issue(0, 24'h341201, 1'b0);
        @(posedge clk); #1;
        check("t1_busy_arb", 32'(busy), 32'd1);
        check("t1_go_c1", 32'(go), 32'd0);
        @(posedge clk); #1;
        check("t1_gnt", 32'(gnt), 32'b001);
        check("t1_go_c2", 32'(go), 32'd0);
        check("t1_latched", 32'(i2c_data), 32'h341201);
        @(posedge clk); #1;
        check("t1_go_c3", 32'(go), 32'd1);
        wait_quiet();
        check("t1_go_pulses", 32'(go_pulses), 32'd1);

        // Simultaneous requests from a fresh pointer: served 0,1,2; then 0 before 2.
        do_reset();
        issue(0, 24'h1A0001, 1'b0);
        issue(1, 24'h1A0102, 1'b0);
        issue(2, 24'h1A0203, 1'b0);
        wait_quiet();
        @(negedge clk);
        issue(0, 24'h2B0010, 1'b0);
        issue(2, 24'h2B0220, 1'b0);
        wait_quiet();

        // NACK handling.
        @(negedge clk);
`ifdef I2C_ARB_RETRY_EN
        go_pulses = 0;
        nack_left = 2;
        issue(1, 24'h3C0155, 1'b0);
        wait_quiet();
        check("t3_retry_pulses", 32'(go_pulses), 32'd3);
        @(negedge clk);
        go_pulses = 0;
        nack_left = 1000;
        issue(1, 24'h3C0166, 1'b1);
        wait_quiet();
        check("t3_exhaust_pulses", 32'(go_pulses), 32'd4);
`else
        go_pulses = 0;
        nack_left = 1000;
        issue(1, 24'h3C0166, 1'b1);
        wait_quiet();
        check("t3_single_pulse", 32'(go_pulses), 32'd1);
`endif
        nack_left = 0;

        // Controller never ends: timeout after 64 cycles of GO.
        @(negedge clk);
        hang = 1'b1;
        go_pulses = 0;
        go_hi = 0;
        issue(2, 24'h4D0277, 1'b1);
        wait_quiet();
        check("t4_go_pulses", 32'(go_pulses), 32'd1);
        check("t4_go_width", 32'(go_hi), 32'd64);

        // Reset while GO is high, then the same requester restarts cleanly.
        @(negedge clk);
        req_data[0 +: DW] = 24'h5E0088;
        req[0] = 1'b1;
        begin
            int n;
            n = 0;
            while (!go && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("t5_go_seen", 32'(go), 32'd1);
        end
        rst = 1'b1;
        #1;
        check("t5_rst_go", 32'(go), 32'd0);
        check("t5_rst_gnt", 32'(gnt), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        begin
            exp_t x;
            x.idx = 0; x.err = 1'b0; x.data = 24'h5E0088;
            sb.push_back(x);
        end
        hang = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_quiet();

        // Data and request dropped after ARB: latched word kept, oDONE still pulses.
        @(negedge clk);
        issue(2, 24'hABCDEF, 1'b0);
        begin
            int n;
            n = 0;
            while (!gnt[2] && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("t6_gnt_seen", 32'(gnt), 32'b100);
        end
        req_data[2*DW +: DW] = 24'h000000;
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_data_hold", 32'(i2c_data), 32'hABCDEF);
        wait_quiet();

        repeat (3) @(negedge clk);
        check("gnt_onehot", 32'(onehot_bad), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
